// File: rtl/l1d_cache_ctrl.sv
// l1d_cache_ctrl: direct-mapped, write-back, write-allocate L1 data cache
// controller sitting between the CPU load/store port and a burst memory.
//
// Ports:
//   CLK, RST_N                  clock (rising edge), synchronous active-low reset
//   LOAD, STORE, ADDR, WDATA    CPU request (sampled only while BUSY=0)
//   RDATA, DONE, BUSY           CPU response / back-pressure
//   MEM_VALID, MEM_WE, MEM_ADDR burst request (write-back or fill), line aligned
//   MEM_ACK_ADDR                memory accepted the burst request
//   MEM_WDATA, MEM_WVALID       write-back beat, MEM_ACK_DATA accepts it
//   MEM_RDATA, MEM_RVALID       fill beat
//   HIT_CNT, MISS_CNT           saturating hit/miss counters, present only
//                               when L1D_PERF_CNT_EN is defined
//
// Optional feature macro: L1D_PERF_CNT_EN.
module l1d_cache_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LOAD,
  input  logic              STORE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              DONE,
  output logic              BUSY,
  output logic              MEM_VALID,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WVALID,
  input  logic              MEM_ACK_DATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_RVALID
`ifdef L1D_PERF_CNT_EN
  ,
  output logic [31:0]       HIT_CNT,
  output logic [31:0]       MISS_CNT
`endif
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int RAM_AW = IDX_W + OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [OFF_W-1:0] OFF_ZERO  = '0;

  typedef enum logic [2:0] {IDLE, RESP, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA} state_t;

  state_t state_reg;

  // Line state: valid/dirty reset, tags and data are not.
  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] dirty_reg;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [DATA_W-1:0]    data_mem [NUM_LINES*WORDS_PER_LINE];

  // Captured request
  logic [TAG_W-1:0]  req_tag_reg;
  logic [IDX_W-1:0]  req_idx_reg;
  logic [OFF_W-1:0]  req_off_reg;
  logic [DATA_W-1:0] req_wdata_reg;
  logic              req_store_reg;

  logic [OFF_W-1:0]  beat_reg;
  logic [DATA_W-1:0] fill_word_reg;   // target word captured as it streams by
  logic [DATA_W-1:0] rdata_reg;       // load result of a miss
  logic              rdata_sel_reg;   // 1: load hit, result comes straight from the RAM
  logic [DATA_W-1:0] ram_q;

  // Incoming address fields
  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] a_idx;
  logic [OFF_W-1:0] a_off;
  assign a_tag = ADDR[ADDR_W-1 -: TAG_W];
  assign a_idx = ADDR[OFF_W +: IDX_W];
  assign a_off = ADDR[OFF_W-1:0];

  logic accepting, req_valid, hit, victim_dirty, fill_last;
  logic [OFF_W-1:0] beat_next;
  assign accepting    = (state_reg == IDLE) || (state_reg == RESP);
  assign req_valid    = accepting && (LOAD || STORE);
  assign hit          = valid_reg[a_idx] && (tag_mem[a_idx] == a_tag);
  assign victim_dirty = valid_reg[a_idx] && dirty_reg[a_idx];
  assign beat_next    = beat_reg + OFF_W'(1);
  assign fill_last    = (state_reg == FILL_DATA) && MEM_RVALID && (beat_reg == LAST_BEAT);

  // Single RAM write port: store hits, or fill beats (with the pending store
  // merged into its target word as it arrives).
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [RAM_AW-1:0] ram_raddr;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = {a_idx, a_off};
    ram_wdata = WDATA;
    if (req_valid && STORE && hit) begin
      ram_we = 1'b1;
    end else if ((state_reg == FILL_DATA) && MEM_RVALID) begin
      ram_we    = 1'b1;
      ram_waddr = {req_idx_reg, beat_reg};
      ram_wdata = (req_store_reg && (beat_reg == req_off_reg)) ? req_wdata_reg : MEM_RDATA;
    end
  end

  // Read address is prefetched one beat ahead during write-back so that
  // MEM_WDATA always shows the word of the current beat.
  always_comb begin
    case (state_reg)
      WB_REQ:  ram_raddr = {req_idx_reg, OFF_ZERO};
      WB_DATA: ram_raddr = {req_idx_reg, MEM_ACK_DATA ? beat_next : beat_reg};
      default: ram_raddr = {a_idx, a_off};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (ram_we) data_mem[ram_waddr] <= ram_wdata;
    ram_q <= data_mem[ram_raddr];
  end

  always_ff @(posedge CLK) begin
    if (fill_last) tag_mem[req_idx_reg] <= req_tag_reg;
  end

  assign RDATA     = rdata_sel_reg ? ram_q : rdata_reg;
  assign MEM_WDATA = MEM_WVALID ? ram_q : '0;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      valid_reg     <= '0;
      dirty_reg     <= '0;
      DONE          <= 1'b0;
      BUSY          <= 1'b0;
      MEM_VALID     <= 1'b0;
      MEM_WE        <= 1'b0;
      MEM_ADDR      <= '0;
      MEM_WVALID    <= 1'b0;
      rdata_reg     <= '0;
      rdata_sel_reg <= 1'b0;
      beat_reg      <= '0;
      fill_word_reg <= '0;
      req_tag_reg   <= '0;
      req_idx_reg   <= '0;
      req_off_reg   <= '0;
      req_wdata_reg <= '0;
      req_store_reg <= 1'b0;
    end else begin
      case (state_reg)
        // RESP also accepts, so hits can issue every cycle.
        IDLE, RESP: begin
          DONE          <= 1'b0;
          rdata_sel_reg <= 1'b0;
          state_reg     <= IDLE;
          if (req_valid) begin
            req_tag_reg   <= a_tag;
            req_idx_reg   <= a_idx;
            req_off_reg   <= a_off;
            req_wdata_reg <= WDATA;
            req_store_reg <= STORE;   // LOAD+STORE together is a store
            if (hit) begin
              DONE          <= 1'b1;
              rdata_sel_reg <= !STORE;
              state_reg     <= RESP;
              if (STORE) dirty_reg[a_idx] <= 1'b1;
            end else begin
              BUSY      <= 1'b1;
              MEM_VALID <= 1'b1;
              beat_reg  <= '0;
              if (victim_dirty) begin
                MEM_WE    <= 1'b1;
                MEM_ADDR  <= {tag_mem[a_idx], a_idx, OFF_ZERO};
                state_reg <= WB_REQ;
              end else begin
                MEM_WE    <= 1'b0;
                MEM_ADDR  <= {a_tag, a_idx, OFF_ZERO};
                state_reg <= FILL_REQ;
              end
            end
          end
        end
        WB_REQ: begin
          if (MEM_ACK_ADDR) begin
            MEM_VALID  <= 1'b0;
            MEM_WVALID <= 1'b1;
            state_reg  <= WB_DATA;
          end
        end
        WB_DATA: begin
          if (MEM_ACK_DATA) begin
            beat_reg <= beat_next;
            if (beat_reg == LAST_BEAT) begin
              MEM_WVALID             <= 1'b0;
              dirty_reg[req_idx_reg] <= 1'b0;
              MEM_VALID              <= 1'b1;
              MEM_WE                 <= 1'b0;
              MEM_ADDR               <= {req_tag_reg, req_idx_reg, OFF_ZERO};
              state_reg              <= FILL_REQ;
            end
          end
        end
        FILL_REQ: begin
          if (MEM_ACK_ADDR) begin
            MEM_VALID <= 1'b0;
            state_reg <= FILL_DATA;
          end
        end
        FILL_DATA: begin
          if (MEM_RVALID) begin
            beat_reg <= beat_next;
            if (beat_reg == req_off_reg) fill_word_reg <= MEM_RDATA;
            if (beat_reg == LAST_BEAT) begin
              valid_reg[req_idx_reg] <= 1'b1;
              dirty_reg[req_idx_reg] <= req_store_reg;
              DONE                   <= 1'b1;
              BUSY                   <= 1'b0;
              state_reg              <= RESP;
              // Target may be the beat arriving right now.
              if (!req_store_reg)
                rdata_reg <= (req_off_reg == LAST_BEAT) ? MEM_RDATA : fill_word_reg;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef L1D_PERF_CNT_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (req_valid) begin
      if (hit) begin
        if (hit_cnt_reg != 32'hFFFF_FFFF) hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end else begin
        if (miss_cnt_reg != 32'hFFFF_FFFF) miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign HIT_CNT  = hit_cnt_reg;
  assign MISS_CNT = miss_cnt_reg;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_l1d_cache_ctrl.sv
// Directed, self-checking bench for l1d_cache_ctrl with a behavioural burst
// memory and scoreboard queues for bursts, write-back beats and completions.
module tb_l1d_cache_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        LOAD, STORE;
  logic [31:0] ADDR, WDATA;
  logic [31:0] RDATA;
  logic        DONE, BUSY;
  logic        MEM_VALID, MEM_WE;
  logic [31:0] MEM_ADDR;
  logic        MEM_ACK_ADDR;
  logic [31:0] MEM_WDATA;
  logic        MEM_WVALID;
  logic        MEM_ACK_DATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_RVALID;
`ifdef L1D_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 CLK = ~CLK;

  l1d_cache_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .STORE(STORE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(RDATA), .DONE(DONE), .BUSY(BUSY),
    .MEM_VALID(MEM_VALID), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_ACK_ADDR(MEM_ACK_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_WVALID(MEM_WVALID), .MEM_ACK_DATA(MEM_ACK_DATA),
    .MEM_RDATA(MEM_RDATA), .MEM_RVALID(MEM_RVALID)
`ifdef L1D_PERF_CNT_EN
    , .HIT_CNT(hit_cnt), .MISS_CNT(miss_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem_model [256];
  logic [32:0] exp_burst_q [$];   // {we, addr}
  logic [31:0] exp_wb_q    [$];
  logic [32:0] exp_done_q  [$];   // {is_load, rdata}
  int          exp_done_total = 0;
  int          done_cnt = 0;

  bit resp_en       = 1'b0;
  int addr_delay    = 0;
  int wb_stall      = 0;
  bit fill_gap      = 1'b0;
  int reset_at_beat = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push_done(input logic is_load, input logic [31:0] data);
    exp_done_q.push_back({is_load, data});
    exp_done_total++;
  endtask

  // Called at a negedge; returns at the negedge right after acceptance.
  task automatic cpu_req(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] wd);
    for (int g = 0; g < 300 && BUSY; g++) @(negedge CLK);
    LOAD = ld; STORE = st; ADDR = a; WDATA = wd;
    @(negedge CLK);
    LOAD = 1'b0; STORE = 1'b0;
  endtask

  task automatic wait_done();
    for (int g = 0; g < 300 && done_cnt < exp_done_total; g++) @(negedge CLK);
    chk("done_count", 32'(done_cnt), 32'(exp_done_total));
  endtask

  // Completion monitor
  initial begin : done_monitor
    logic [32:0] e;
    forever begin
      @(negedge CLK);
      if (RST_N && DONE) begin
        done_cnt++;
        chk("done_expected", 32'(exp_done_q.size() != 0), 32'd1);
        if (exp_done_q.size() != 0) begin
          e = exp_done_q.pop_front();
          if (e[32]) chk("rdata", RDATA, e[31:0]);
        end
      end
    end
  end

  // Burst memory responder
  initial begin : mem_responder
    logic        we;
    logic [31:0] base;
    logic [32:0] e;
    logic [7:0]  mi;
    MEM_ACK_ADDR = 1'b0; MEM_ACK_DATA = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = '0;
    forever begin
      @(negedge CLK);
      MEM_ACK_ADDR = 1'b0; MEM_ACK_DATA = 1'b0; MEM_RVALID = 1'b0;
      if (resp_en && RST_N && MEM_VALID) begin
        repeat (addr_delay) @(negedge CLK);
        chk("burst_expected", 32'(exp_burst_q.size() != 0), 32'd1);
        if (exp_burst_q.size() != 0) begin
          e = exp_burst_q.pop_front();
          chk("mem_we", 32'(MEM_WE), 32'(e[32]));
          chk("mem_addr", MEM_ADDR, e[31:0]);
        end
        we = MEM_WE; base = MEM_ADDR;
        MEM_ACK_ADDR = 1'b1;
        @(negedge CLK);
        MEM_ACK_ADDR = 1'b0;
        chk("mem_valid_drop", 32'(MEM_VALID), 32'd0);
        if (we) begin
          for (int i = 0; i < 4; i++) begin
            if (!RST_N) break;
            for (int g = 0; g < 50 && !MEM_WVALID; g++) @(negedge CLK);
            chk("wvalid", 32'(MEM_WVALID), 32'd1);
            repeat (wb_stall) @(negedge CLK);
            mi = base[7:0] + 8'(i);
            if (exp_wb_q.size() != 0) chk("wb_beat", MEM_WDATA, exp_wb_q.pop_front());
            mem_model[mi] = MEM_WDATA;
            MEM_ACK_DATA = 1'b1;
            @(negedge CLK);
            MEM_ACK_DATA = 1'b0;
          end
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (!RST_N) break;
            if (i == 2 && fill_gap) @(negedge CLK);   // idle gap after beat 1
            mi = base[7:0] + 8'(i);
            MEM_RVALID = 1'b1;
            MEM_RDATA  = mem_model[mi];
            if (i == reset_at_beat) RST_N = 1'b0;
            @(negedge CLK);
            MEM_RVALID = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    for (int i = 0; i < 256; i++) mem_model[i] = 32'h100 + 32'(i);
    mem_model[8'h10] = 32'hA0; mem_model[8'h11] = 32'hA1;
    mem_model[8'h12] = 32'hA2; mem_model[8'h13] = 32'hA3;
    mem_model[8'h50] = 32'hB0; mem_model[8'h51] = 32'hB1;
    mem_model[8'h52] = 32'hB2; mem_model[8'h53] = 32'hB3;

    RST_N = 1'b0; LOAD = 1'b0; STORE = 1'b0; ADDR = '0; WDATA = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_mem_valid", 32'(MEM_VALID), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_mem_we", 32'(MEM_WE), 32'd0);
    chk("rst_mem_addr", MEM_ADDR, 32'd0);
    chk("rst_mem_wvalid", 32'(MEM_WVALID), 32'd0);
    chk("rst_mem_wdata", MEM_WDATA, 32'd0);

    // Cold miss is visible on the memory side (memory silent here)
    cpu_req(1'b1, 1'b0, 32'h10, 32'h0);
    chk("first_miss_busy", 32'(BUSY), 32'd1);
    chk("first_miss_mem_valid", 32'(MEM_VALID), 32'd1);
    chk("first_miss_mem_addr", MEM_ADDR, 32'h10);
    chk("first_miss_mem_we", 32'(MEM_WE), 32'd0);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rerst_mem_valid", 32'(MEM_VALID), 32'd0);
    resp_en = 1'b1;

    // Cold load miss, last word forwarded from the final beat
    addr_delay = 2; fill_gap = 1'b1;
    exp_burst_q.push_back({1'b0, 32'h10});
    push_done(1'b1, 32'hA3);
    cpu_req(1'b1, 1'b0, 32'h13, 32'h0);
    chk("cold_busy", 32'(BUSY), 32'd1);
    wait_done();

    // Hit latency
    push_done(1'b1, 32'hA1);
    cpu_req(1'b1, 1'b0, 32'h11, 32'h0);
    chk("load_hit_done", 32'(DONE), 32'd1);
    chk("load_hit_busy", 32'(BUSY), 32'd0);
    wait_done();
    push_done(1'b0, 32'h0);
    cpu_req(1'b0, 1'b1, 32'h12, 32'h55);
    chk("store_hit_done", 32'(DONE), 32'd1);
    chk("store_hit_busy", 32'(BUSY), 32'd0);
    wait_done();

    // Back-to-back hits, one per cycle
    push_done(1'b1, 32'hA0);
    push_done(1'b1, 32'h55);
    LOAD = 1'b1; ADDR = 32'h10;
    @(negedge CLK);
    chk("b2b_done0", 32'(DONE), 32'd1);
    ADDR = 32'h12;
    @(negedge CLK);
    LOAD = 1'b0;
    chk("b2b_done1", 32'(DONE), 32'd1);
    chk("b2b_busy", 32'(BUSY), 32'd0);
    wait_done();

    // Dirty eviction: write-back of line 0x10 then fill of 0x50
    addr_delay = 1; wb_stall = 1;
    exp_burst_q.push_back({1'b1, 32'h10});
    exp_burst_q.push_back({1'b0, 32'h50});
    exp_wb_q.push_back(32'hA0); exp_wb_q.push_back(32'hA1);
    exp_wb_q.push_back(32'h55); exp_wb_q.push_back(32'hA3);
    push_done(1'b1, 32'hB2);
    cpu_req(1'b1, 1'b0, 32'h52, 32'h0);
    chk("evict_busy", 32'(BUSY), 32'd1);
    wait_done();
    chk("wb_mem_word2", mem_model[8'h12], 32'h55);

    // LOAD+STORE together behaves as a store
    push_done(1'b0, 32'h0);
    cpu_req(1'b1, 1'b1, 32'h51, 32'h77);
    chk("both_hit_done", 32'(DONE), 32'd1);
    wait_done();
    push_done(1'b1, 32'h77);
    cpu_req(1'b1, 1'b0, 32'h51, 32'h0);
    wait_done();

    // Reset during fill beat 2, then the line must miss again
    exp_burst_q.push_back({1'b0, 32'h20});
    reset_at_beat = 2;
    cpu_req(1'b1, 1'b0, 32'h23, 32'h0);
    for (int g = 0; g < 200 && RST_N; g++) @(negedge CLK);
    chk("mid_fill_reset_seen", 32'(RST_N), 32'd0);
    reset_at_beat = -1;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_mem_valid", 32'(MEM_VALID), 32'd0);
    exp_burst_q.push_back({1'b0, 32'h20});
    push_done(1'b1, 32'h123);
    cpu_req(1'b1, 1'b0, 32'h23, 32'h0);
    chk("refill_busy", 32'(BUSY), 32'd1);
    chk("refill_mem_valid", 32'(MEM_VALID), 32'd1);
    chk("refill_mem_addr", MEM_ADDR, 32'h20);
    wait_done();

    repeat (3) @(negedge CLK);
    chk("burst_q_drained", 32'(exp_burst_q.size()), 32'd0);
    chk("wb_q_drained", 32'(exp_wb_q.size()), 32'd0);
    chk("done_q_drained", 32'(exp_done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
